// File: rtl/partial_product_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module   : partial_product_accumulator_if
// Brief    : Partial-product input stream and product output stream bundle.
// Revision : 1.0
// ============================================================================
interface partial_product_accumulator_if #(
    parameter int PP_WIDTH  = 40,
    parameter int NUM_PP    = 4,
    parameter int OUT_WIDTH = 64
);
    localparam int IDX_W = (NUM_PP > 1) ? $clog2(NUM_PP) : 1;

    logic                 in_valid;
    logic                 in_ready;
    logic [PP_WIDTH-1:0]  pp;
    logic [IDX_W-1:0]     pp_idx;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] product;

    modport master (
        output in_valid, pp, out_ready,
        input  in_ready, pp_idx, out_valid, product
    );

    modport slave (
        input  in_valid, pp, out_ready,
        output in_ready, pp_idx, out_valid, product
    );
endinterface
`default_nettype wire

// File: rtl/partial_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : partial_product_accumulator
// Brief    : Shifts and sums NUM_PP 32x8 partial products into a full product.
// Revision : 1.0
// ============================================================================
module partial_product_accumulator #(
    parameter int PP_WIDTH  = 40,
    parameter int NUM_PP    = 4,
    parameter int STEP      = 8,
    parameter int OUT_WIDTH = 64
) (
    input  wire                            clk,
    input  wire                            nrst,
    input  wire                            clr,
    partial_product_accumulator_if.slave   bus
);
    localparam int IDX_W = (NUM_PP > 1) ? $clog2(NUM_PP) : 1;
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_PP - 1);

    typedef enum logic [0:0] {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [OUT_WIDTH-1:0] r_acc;
    logic [IDX_W-1:0]     r_cnt;
    logic [OUT_WIDTH-1:0] r_product;

    logic                 w_accept;
    logic                 w_last;
    logic [31:0]          w_shift_amt;
    logic [OUT_WIDTH-1:0] w_pp_ext;
    logic [OUT_WIDTH-1:0] w_sum;

    // clr wins over both handshakes, so it masks the accept here.
    assign w_accept    = bus.in_valid && (r_state == ST_ACC) && !clr;
    assign w_last      = (r_cnt == c_LAST_IDX);
    assign w_shift_amt = 32'(r_cnt) * 32'(STEP);
    assign w_pp_ext    = OUT_WIDTH'(bus.pp);
    assign w_sum       = r_acc + (w_pp_ext << w_shift_amt);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clr) begin
            w_state_nxt = ST_ACC;
        end else begin
            case (r_state)
                ST_ACC: if (w_accept && w_last) w_state_nxt = ST_OUT;
                ST_OUT: if (bus.out_ready)      w_state_nxt = ST_ACC;
                default:                        w_state_nxt = ST_ACC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (clr) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            if (w_last) begin
                r_product <= w_sum;
                r_acc     <= '0;
                r_cnt     <= '0;
            end else begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Handshake outputs depend only on state; out_ready never reaches in_ready.
    assign bus.in_ready  = (r_state == ST_ACC);
    assign bus.out_valid = (r_state == ST_OUT);
    assign bus.product   = r_product;
    assign bus.pp_idx    = r_cnt;
endmodule
`default_nettype wire

// File: tb/tb_partial_product_accumulator.sv
`default_nettype none
// Bench for partial_product_accumulator: per-scenario tasks with a product
// scoreboard popped by a negedge monitor on every output transfer.
module tb_partial_product_accumulator;
    localparam int PP_WIDTH  = 40;
    localparam int NUM_PP    = 4;
    localparam int STEP      = 8;
    localparam int OUT_WIDTH = 64;

    logic clk  = 1'b0;
    logic nrst = 1'b1;
    logic clr  = 1'b0;

    int vectors     = 0;
    int miscompares = 0;
    logic [63:0] sb_q[$];

    partial_product_accumulator_if #(
        .PP_WIDTH(PP_WIDTH), .NUM_PP(NUM_PP), .OUT_WIDTH(OUT_WIDTH)
    ) bus ();

    partial_product_accumulator #(
        .PP_WIDTH(PP_WIDTH), .NUM_PP(NUM_PP), .STEP(STEP), .OUT_WIDTH(OUT_WIDTH)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .clr  (clr),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        logic [63:0] e;
        if (nrst && !clr && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            vectors++;
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_empty: got product %h, want no transfer", bus.product);
            end else begin
                e = sb_q.pop_front();
                if (bus.product !== e) begin
                    miscompares++;
                    $display("FAIL scoreboard_product: got %h want %h", bus.product, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PP_WIDTH-1:0] pp_of(input logic [31:0] a, input logic [31:0] b,
                                                 input int i);
        logic [7:0] bb;
        bb = b[8*i +: 8];
        return 40'(a) * 40'(bb);
    endfunction

    task automatic feed(input logic [31:0] a, input logic [31:0] b);
        sb_q.push_back(64'(a) * 64'(b));
        for (int i = 0; i < NUM_PP; i++) begin
            bus.in_valid = 1'b1;
            bus.pp       = pp_of(a, b, i);
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1 nrst = 1'b0;
        tick();
        tick();
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.product !== 64'h0 ||
            bus.pp_idx !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_state: got rdy=%b vld=%b prod=%h idx=%0d want 1 0 0 0",
                     bus.in_ready, bus.out_valid, bus.product, bus.pp_idx);
        end
        nrst = 1'b1;
        tick();
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: got rdy=%b vld=%b want 1 0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_full_ones();
        sb_q.push_back(64'hFFFFFFFE00000001);
        for (int i = 0; i < NUM_PP; i++) begin
            bus.in_valid = 1'b1;
            bus.pp       = 40'hFEFFFFFF01;
            vectors++;
            if (bus.in_ready !== 1'b1 || bus.pp_idx !== 2'(i)) begin
                miscompares++;
                $display("FAIL ones_accept%0d: got rdy=%b idx=%0d want 1 %0d",
                         i, bus.in_ready, bus.pp_idx, i);
            end
            tick();
        end
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ones_latency: got vld=%b rdy=%b want 1 0", bus.out_valid, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.pp_idx !== 2'd0) begin
            miscompares++;
            $display("FAIL ones_after_xfer: got vld=%b rdy=%b idx=%0d want 0 1 0",
                     bus.out_valid, bus.in_ready, bus.pp_idx);
        end
    endtask

    task automatic test_gaps();
        logic [PP_WIDTH-1:0] seq [4];
        seq[0] = 40'h0;
        seq[1] = 40'h0012345678;
        seq[2] = 40'h0;
        seq[3] = 40'h0;
        sb_q.push_back(64'h0000001234567800);
        for (int i = 0; i < NUM_PP; i++) begin
            bus.in_valid = 1'b0;
            bus.pp       = 40'hAAAAAAAAAA;
            tick();
            vectors++;
            if (bus.pp_idx !== 2'(i)) begin
                miscompares++;
                $display("FAIL gaps_idx_hold%0d: got %0d want %0d", i, bus.pp_idx, i);
            end
            bus.in_valid = 1'b1;
            bus.pp       = seq[i];
            tick();
        end
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL gaps_valid: got %b want 1", bus.out_valid);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_hold();
        logic [63:0] exp;
        exp = 64'h0000ABCD * 64'h01020304;
        feed(32'h0000ABCD, 32'h01020304);
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = c[0];
            bus.pp       = 40'hFFFFFFFFFF;
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.product !== exp) begin
                miscompares++;
                $display("FAIL hold_cycle%0d: got vld=%b rdy=%b prod=%h want 1 0 %h",
                         c, bus.out_valid, bus.in_ready, bus.product, exp);
            end
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.pp_idx !== 2'd0) begin
            miscompares++;
            $display("FAIL hold_release: got vld=%b rdy=%b idx=%0d want 0 1 0",
                     bus.out_valid, bus.in_ready, bus.pp_idx);
        end
    endtask

    task automatic test_clr();
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.pp       = 40'h5;
            tick();
        end
        bus.pp = 40'h7;
        clr    = 1'b1;
        tick();
        clr          = 1'b0;
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.pp_idx !== 2'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL clr_acc: got idx=%0d vld=%b rdy=%b want 0 0 1",
                     bus.pp_idx, bus.out_valid, bus.in_ready);
        end
        feed(32'h1, 32'h01010101);
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.product !== 64'h0000000001010101) begin
            miscompares++;
            $display("FAIL clr_product: got vld=%b prod=%h want 1 0000000001010101",
                     bus.out_valid, bus.product);
        end
        // clr with out_ready in OUT: no transfer, product kept but invalid.
        bus.out_ready = 1'b1;
        clr           = 1'b1;
        tick();
        clr           = 1'b0;
        bus.out_ready = 1'b0;
        void'(sb_q.pop_front());
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
            bus.product !== 64'h0000000001010101) begin
            miscompares++;
            $display("FAIL clr_in_out: got vld=%b rdy=%b prod=%h want 0 1 0000000001010101",
                     bus.out_valid, bus.in_ready, bus.product);
        end
    endtask

    task automatic test_async_reset();
        feed(32'hCAFEBABE, 32'h00FF10AB);
        vectors++;
        if (bus.out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL arst_pre: got vld=%b want 1", bus.out_valid);
        end
        #2 nrst = 1'b0;
        #1;
        void'(sb_q.pop_front());
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.product !== 64'h0 || bus.pp_idx !== 2'd0 ||
            bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL arst_immediate: got vld=%b prod=%h idx=%0d rdy=%b want 0 0 0 1",
                     bus.out_valid, bus.product, bus.pp_idx, bus.in_ready);
        end
        @(negedge clk);
        nrst = 1'b1;
        tick();
        feed(32'hDEADBEEF, 32'h87654321);
        for (int t = 0; t < 10 && bus.out_valid !== 1'b1; t++) tick();
        vectors++;
        if (bus.out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL arst_timeout: got vld=%b want 1", bus.out_valid);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] av [3];
        logic [31:0] bv [3];
        int k;
        int seen[$];
        av[0] = 32'hFFFFFFFF; bv[0] = 32'hFFFFFFFF;
        av[1] = 32'h13579BDF; bv[1] = 32'h2468ACE0;
        av[2] = 32'h0000FFFF; bv[2] = 32'hFFFF0000;
        k = 0;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (bus.out_valid === 1'b1) seen.push_back(cyc);
            bus.in_valid = (k < 12);
            if (k < 12) bus.pp = pp_of(av[k/4], bv[k/4], k % 4);
            if (k < 12 && bus.in_ready === 1'b1) begin
                if (k % 4 == 0) sb_q.push_back(64'(av[k/4]) * 64'(bv[k/4]));
                k++;
            end
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        vectors++;
        if (seen.size() != 3 || k != 12) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d products %0d accepts want 3 12", seen.size(), k);
        end else begin
            vectors++;
            if (seen[0] != 4 || seen[1] - seen[0] != 5 || seen[2] - seen[1] != 5) begin
                miscompares++;
                $display("FAIL b2b_period: got cycles %0d %0d %0d want 4 9 14",
                         seen[0], seen[1], seen[2]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.pp        = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_full_ones();
        test_gaps();
        test_hold();
        test_clr();
        test_async_reset();
        test_back_to_back();
        tick();
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_leftover: got %0d pending want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
